// File: rtl/spi_video_rx.sv
// spi_video_rx: SPI MISO receive stage for the video frame banks.
// Hunts for a bit-aligned header, deserializes the payload MSB-first into
// bytes and writes them into the bank that was writable at header time.
// Optional trailer checksum: define VIDEO_RX_CHECKSUM_EN.
module spi_video_rx #(
   parameter int unsigned FRAME_BYTES = 9600,
   parameter int unsigned ADDR_W      = 14,
   parameter logic [7:0]  HEADER      = 8'hFF
) (
   input  logic              CLK_40,
   input  logic              reset,
   input  logic              SPI_clk_en,
   input  logic              chip_select,
   input  logic              MISO,
   input  logic              write_bank1,
   input  logic              write_bank2,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              video_data_ready,
   output logic              frame_abort,
   output logic              busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HUNT,
      ST_PAYLOAD,
`ifdef VIDEO_RX_CHECKSUM_EN
      ST_CHECK,
`endif
      ST_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

   state_t              state_q, state_d;
   logic [7:0]          sr_q, sr_d;
   logic [7:0]          byte_q, byte_d;
   logic [2:0]          bitcnt_q, bitcnt_d;
   logic [ADDR_W-1:0]   bytecnt_q, bytecnt_d;
   logic                bank_q, bank_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]          wr_data_q, wr_data_d;
   logic                rdy_q, rdy_d;
   logic                abort_q, abort_d;
`ifdef VIDEO_RX_CHECKSUM_EN
   logic [7:0]          xor_q, xor_d;
`endif

   logic       sample;
   logic [7:0] sr_shift;
   logic [7:0] byte_shift;

   assign sample     = SPI_clk_en & ~chip_select;
   assign sr_shift   = {sr_q[6:0], MISO};
   assign byte_shift = {byte_q[6:0], MISO};

   // Next-state and registered-output decode
   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      byte_d    = byte_q;
      bitcnt_d  = bitcnt_q;
      bytecnt_d = bytecnt_q;
      bank_d    = bank_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rdy_d     = 1'b0;
      abort_d   = 1'b0;
`ifdef VIDEO_RX_CHECKSUM_EN
      xor_d     = xor_q;
`endif
      case (state_q)
         ST_IDLE: begin
            sr_d = '0;
            if (!chip_select) state_d = ST_HUNT;
         end
         ST_HUNT: begin
            if (chip_select) begin
               state_d = ST_IDLE;
            end else if (sample) begin
               sr_d = sr_shift;
               if (sr_shift == HEADER) begin
                  if (write_bank1 || write_bank2) begin
                     // bank 1 wins when both are writable
                     bank_d    = ~write_bank1;
                     bitcnt_d  = '0;
                     bytecnt_d = '0;
                     byte_d    = '0;
`ifdef VIDEO_RX_CHECKSUM_EN
                     xor_d     = '0;
`endif
                     state_d   = ST_PAYLOAD;
                  end else begin
                     abort_d = 1'b1;
                     sr_d    = '0;
                  end
               end
            end
         end
         ST_PAYLOAD: begin
            if (chip_select) begin
               abort_d = 1'b1;
               state_d = ST_IDLE;
            end else if (sample) begin
               byte_d   = byte_shift;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  wr_en_d   = 1'b1;
                  wr_data_d = byte_shift;
                  wr_addr_d = bytecnt_q;
                  bytecnt_d = bytecnt_q + 1'b1;
`ifdef VIDEO_RX_CHECKSUM_EN
                  xor_d     = xor_q ^ byte_shift;
                  if (bytecnt_q == LAST_ADDR) state_d = ST_CHECK;
`else
                  if (bytecnt_q == LAST_ADDR) state_d = ST_DONE;
`endif
               end
            end
         end
`ifdef VIDEO_RX_CHECKSUM_EN
         ST_CHECK: begin
            if (chip_select) begin
               abort_d = 1'b1;
               state_d = ST_IDLE;
            end else if (sample) begin
               byte_d   = byte_shift;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  if (byte_shift == xor_q) begin
                     state_d = ST_DONE;
                  end else begin
                     abort_d = 1'b1;
                     sr_d    = '0;
                     state_d = ST_HUNT;
                  end
               end
            end
         end
`endif
         ST_DONE: begin
            rdy_d   = 1'b1;
            sr_d    = '0;
            state_d = chip_select ? ST_IDLE : ST_HUNT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge CLK_40 or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         byte_q    <= '0;
         bitcnt_q  <= '0;
         bytecnt_q <= '0;
         bank_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rdy_q     <= 1'b0;
         abort_q   <= 1'b0;
`ifdef VIDEO_RX_CHECKSUM_EN
         xor_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         byte_q    <= byte_d;
         bitcnt_q  <= bitcnt_d;
         bytecnt_q <= bytecnt_d;
         bank_q    <= bank_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rdy_q     <= rdy_d;
         abort_q   <= abort_d;
`ifdef VIDEO_RX_CHECKSUM_EN
         xor_q     <= xor_d;
`endif
      end
   end

   assign wr_en            = wr_en_q;
   assign wr_bank          = bank_q;
   assign wr_addr          = wr_addr_q;
   assign wr_data          = wr_data_q;
   assign video_data_ready = rdy_q;
   assign frame_abort      = abort_q;
`ifdef VIDEO_RX_CHECKSUM_EN
   assign busy = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
`else
   assign busy = (state_q == ST_PAYLOAD);
`endif

endmodule
